// File: rtl/zebra_stripe_scanner.sv
// -----------------------------------------------------------------------------
// zebra_stripe_scanner
//
// Purpose:
//   Scans a frame held in an external single-port BRAM (2 bits per pixel) for
//   a pedestrian-crossing pattern. NUM_LINES evenly spaced horizontal rows
//   inside the region of interest are read pixel by pixel.
//
//   On each row, maximal white runs whose length lies in [MIN_RUN, MAX_RUN]
//   are counted as stripes. A row is a "hit" when it has at least MIN_STRIPES
//   stripes. A crossing is declared when at least MIN_LINES rows are hits.
//
//   Pixel encoding: 01 and 10 are white; 00 and 11 are black.
//
// Optional feature (macro ZEBRA_GAP_CHECK_EN):
//   When defined, the stripes on a row are split into sequences. A stripe
//   that follows more than MAX_GAP black pixels since the previous counted
//   stripe starts a new sequence. The row count is then the length of the
//   longest sequence. When undefined, no gap hardware exists.
//
// Ports:
//   clk               in   sole clock
//   rst_n             in   asynchronous active-low reset
//   valid_to_read     in   frame-ready request, sampled only when idle
//   bram_addr         out  pixel read address (row-major, y*IMG_WIDTH + x)
//   bram_rd_en        out  read strobe, one address per cycle while scanning
//   bram_data         in   pixel returned one cycle after its address
//   busy              out  scan in progress (through the result cycle)
//   detection_valid   out  one-cycle result strobe
//   crossing_detected out  lines_hit >= MIN_LINES
//   stripe_count      out  largest per-line stripe count in the frame
//   lines_hit         out  number of lines with >= MIN_STRIPES stripes
// -----------------------------------------------------------------------------
module zebra_stripe_scanner #(
   parameter int IMG_WIDTH   = 640,
   parameter int IMG_HEIGHT  = 480,
   parameter int BORDER      = 20,
   parameter int NUM_LINES   = 8,
   parameter int MIN_RUN     = 8,
   parameter int MAX_RUN     = 120,
   parameter int MIN_STRIPES = 3,
   parameter int MIN_LINES   = 2,
   parameter int MAX_GAP     = 100
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    valid_to_read,
   output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] bram_addr,
   output logic                                    bram_rd_en,
   input  logic [1:0]                              bram_data,
   output logic                                    busy,
   output logic                                    detection_valid,
   output logic                                    crossing_detected,
   output logic [7:0]                              stripe_count,
   output logic [4:0]                              lines_hit
);

   localparam int ADDR_W    = $clog2(IMG_WIDTH*IMG_HEIGHT);
   localparam int ROI_W     = IMG_WIDTH - 2*BORDER;
   localparam int ROW_PITCH = (IMG_HEIGHT - 2*BORDER) / NUM_LINES;
   localparam int RUN_W     = $clog2(MAX_RUN + 2);
   localparam int COL_W     = $clog2(ROI_W + 1);
   localparam int LINE_W    = $clog2(NUM_LINES + 1);

   // Address of (x=BORDER, y=BORDER) and the address step between scan rows.
   localparam logic [ADDR_W-1:0] FIRST_ADDR  = ADDR_W'(BORDER*IMG_WIDTH + BORDER);
   localparam logic [ADDR_W-1:0] LINE_STEP   = ADDR_W'(ROW_PITCH*IMG_WIDTH);
   localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(ROI_W - 1);
   localparam logic [LINE_W-1:0] LAST_LINE   = LINE_W'(NUM_LINES - 1);
   localparam logic [RUN_W-1:0]  RUN_SAT     = RUN_W'(MAX_RUN + 1);
   localparam logic [RUN_W-1:0]  RUN_MIN     = RUN_W'(MIN_RUN);
   localparam logic [RUN_W-1:0]  RUN_MAX     = RUN_W'(MAX_RUN);
   localparam logic [7:0]        HIT_STRIPES = 8'(MIN_STRIPES);
   localparam logic [4:0]        HIT_LINES   = 5'(MIN_LINES);

   // Elaboration-time guard against parameter sets the datapath cannot handle.
   if (NUM_LINES < 1 || NUM_LINES > 16 || MIN_RUN < 1 || MAX_RUN < MIN_RUN ||
       MAX_GAP < 0 || ROI_W < 1 || ROW_PITCH < 1) begin : g_bad_params
      $error("zebra_stripe_scanner: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LINE_SETUP = 3'd1,
      S_SCAN       = 3'd2,
      S_DRAIN      = 3'd3,
      S_LINE_END   = 3'd4,
      S_DONE       = 3'd5
   } state_t;

   state_t              state_reg, state_next;
   logic                accept;

   logic [ADDR_W-1:0]   addr_reg;
   logic [ADDR_W-1:0]   row_base_reg;
   logic [COL_W-1:0]    col_reg;
   logic [LINE_W-1:0]   line_reg;
   logic                pix_valid_reg;
   logic [RUN_W-1:0]    run_reg, run_next;
   logic [7:0]          line_cnt_reg, line_cnt_next;
   logic [7:0]          frame_max_reg;
   logic [4:0]          hit_cnt_reg;

   logic                det_valid_reg;
   logic                crossing_reg;
   logic [7:0]          stripe_count_reg;
   logic [4:0]          lines_hit_reg;

   logic                pix_white;
   logic                pix_last;
   logic [RUN_W-1:0]    run_inc;
   logic [RUN_W-1:0]    run_len;
   logic                run_closes;
   logic                stripe_hit;

`ifdef ZEBRA_GAP_CHECK_EN
   localparam int               GAP_W   = $clog2(MAX_GAP + 2);
   localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(MAX_GAP + 1);

   logic [GAP_W-1:0]    gap_reg, gap_next;
   logic [7:0]          seq_reg, seq_next;
`endif

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic. A request is not taken during the result
   // cycle, because busy is still high there.
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (valid_to_read && !det_valid_reg) begin
               accept     = 1'b1;
               state_next = S_LINE_SETUP;
            end
         end
         S_LINE_SETUP: state_next = S_SCAN;
         S_SCAN: begin
            if (col_reg == LAST_COL) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN:    state_next = S_LINE_END;
         S_LINE_END: state_next = (line_reg == LAST_LINE) ? S_DONE : S_LINE_SETUP;
         S_DONE:     state_next = S_IDLE;
         default:    state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      bram_rd_en = (state_reg == S_SCAN);
      busy       = (state_reg != S_IDLE) || det_valid_reg;
   end

   // ------------------------------------------------------------------
   // Pixel classification and run/stripe bookkeeping.
   // pix_valid_reg marks a cycle whose bram_data belongs to the address
   // issued one cycle earlier. The final ROI pixel arrives in DRAIN.
   // ------------------------------------------------------------------
   always_comb begin
      pix_white  = bram_data[1] ^ bram_data[0];
      pix_last   = (state_reg == S_DRAIN);
      run_inc    = (run_reg == RUN_SAT) ? run_reg : run_reg + 1'b1;
      run_len    = pix_white ? run_inc : run_reg;
      run_closes = pix_valid_reg && (!pix_white || pix_last);
      // Over-long runs sit at RUN_SAT, so they fail the upper bound.
      stripe_hit = run_closes && (run_len >= RUN_MIN) && (run_len <= RUN_MAX);

      run_next = run_reg;
      if (pix_valid_reg) begin
         run_next = run_closes ? '0 : run_inc;
      end

      line_cnt_next = line_cnt_reg;
`ifdef ZEBRA_GAP_CHECK_EN
      gap_next = gap_reg;
      seq_next = seq_reg;
      if (stripe_hit) begin
         // A saturated gap means more than MAX_GAP black pixels.
         if (gap_reg == GAP_SAT) begin
            seq_next = 8'd1;
         end else if (seq_reg != 8'hFF) begin
            seq_next = seq_reg + 8'd1;
         end
         // A terminating black pixel is the first pixel of the next gap.
         gap_next = pix_white ? '0 : GAP_W'(1);
         if (seq_next > line_cnt_reg) begin
            line_cnt_next = seq_next;
         end
      end else if (pix_valid_reg && !pix_white && gap_reg != GAP_SAT) begin
         gap_next = gap_reg + 1'b1;
      end
`else
      if (stripe_hit && line_cnt_reg != 8'hFF) begin
         line_cnt_next = line_cnt_reg + 8'd1;
      end
`endif
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg         <= '0;
         row_base_reg     <= '0;
         col_reg          <= '0;
         line_reg         <= '0;
         pix_valid_reg    <= 1'b0;
         run_reg          <= '0;
         line_cnt_reg     <= '0;
         frame_max_reg    <= '0;
         hit_cnt_reg      <= '0;
         det_valid_reg    <= 1'b0;
         crossing_reg     <= 1'b0;
         stripe_count_reg <= '0;
         lines_hit_reg    <= '0;
`ifdef ZEBRA_GAP_CHECK_EN
         gap_reg          <= '0;
         seq_reg          <= '0;
`endif
      end else begin
         pix_valid_reg <= (state_reg == S_SCAN);
         det_valid_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  line_reg      <= '0;
                  row_base_reg  <= FIRST_ADDR;
                  frame_max_reg <= '0;
                  hit_cnt_reg   <= '0;
               end
            end
            S_LINE_SETUP: begin
               addr_reg     <= row_base_reg;
               col_reg      <= '0;
               run_reg      <= '0;
               line_cnt_reg <= '0;
`ifdef ZEBRA_GAP_CHECK_EN
               gap_reg      <= '0;
               seq_reg      <= '0;
`endif
            end
            S_SCAN, S_DRAIN: begin
               if (state_reg == S_SCAN) begin
                  addr_reg <= addr_reg + 1'b1;
                  col_reg  <= col_reg + 1'b1;
               end
               run_reg      <= run_next;
               line_cnt_reg <= line_cnt_next;
`ifdef ZEBRA_GAP_CHECK_EN
               gap_reg      <= gap_next;
               seq_reg      <= seq_next;
`endif
            end
            S_LINE_END: begin
               if (line_cnt_reg > frame_max_reg) begin
                  frame_max_reg <= line_cnt_reg;
               end
               if (line_cnt_reg >= HIT_STRIPES) begin
                  hit_cnt_reg <= hit_cnt_reg + 5'd1;
               end
               line_reg     <= line_reg + 1'b1;
               row_base_reg <= row_base_reg + LINE_STEP;
            end
            S_DONE: begin
               stripe_count_reg <= frame_max_reg;
               lines_hit_reg    <= hit_cnt_reg;
               crossing_reg     <= (hit_cnt_reg >= HIT_LINES);
               det_valid_reg    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bram_addr         = addr_reg;
   assign detection_valid   = det_valid_reg;
   assign crossing_detected = crossing_reg;
   assign stripe_count      = stripe_count_reg;
   assign lines_hit         = lines_hit_reg;

endmodule

// File: tb/tb_zebra_stripe_scanner.sv
module tb_zebra_stripe_scanner;

   localparam int IMG_W       = 640;
   localparam int IMG_H       = 480;
   localparam int BORDER      = 20;
   localparam int NUM_LINES   = 8;
   localparam int MIN_RUN     = 8;
   localparam int MAX_RUN     = 120;
   localparam int MIN_STRIPES = 3;
   localparam int MIN_LINES   = 2;
   localparam int MAX_GAP     = 100;

   localparam int ADDR_W = $clog2(IMG_W*IMG_H);
   localparam int ROI_W  = IMG_W - 2*BORDER;
   localparam int X_END  = IMG_W - BORDER;
   localparam int PITCH  = (IMG_H - 2*BORDER) / NUM_LINES;
   localparam int LAT    = NUM_LINES*(ROI_W + 3) + 1;
   localparam int READS  = NUM_LINES*ROI_W;
`ifdef ZEBRA_GAP_CHECK_EN
   localparam int GAP_EXP = 3;
`else
   localparam int GAP_EXP = 5;
`endif

   logic              clk;
   logic              rst_n;
   logic              valid_to_read;
   logic [ADDR_W-1:0] bram_addr;
   logic              bram_rd_en;
   logic [1:0]        bram_data;
   logic              busy;
   logic              detection_valid;
   logic              crossing_detected;
   logic [7:0]        stripe_count;
   logic [4:0]        lines_hit;

   logic [1:0]        mem [0:IMG_W*IMG_H-1];
   int                rd_cnt;
   int                n_checks;
   int                n_err;

   zebra_stripe_scanner #(
      .IMG_WIDTH(IMG_W), .IMG_HEIGHT(IMG_H), .BORDER(BORDER),
      .NUM_LINES(NUM_LINES), .MIN_RUN(MIN_RUN), .MAX_RUN(MAX_RUN),
      .MIN_STRIPES(MIN_STRIPES), .MIN_LINES(MIN_LINES), .MAX_GAP(MAX_GAP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .valid_to_read(valid_to_read),
      .bram_addr(bram_addr),
      .bram_rd_en(bram_rd_en),
      .bram_data(bram_data),
      .busy(busy),
      .detection_valid(detection_valid),
      .crossing_detected(crossing_detected),
      .stripe_count(stripe_count),
      .lines_hit(lines_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read BRAM with one cycle of latency.
   always @(posedge clk) begin
      if (bram_rd_en) bram_data <= mem[bram_addr];
   end

   initial rd_cnt = 0;
   always @(negedge clk) begin
      if (bram_rd_en === 1'b1) rd_cnt = rd_cnt + 1;
   end

   typedef struct {
      string name;
      int    kind;     // 0: periodic stripes on rows row_lo..row_hi, 1: gap pattern
      int    ww;
      int    wb;
      int    row_lo;
      int    row_hi;
      int    exp_sc;
      int    exp_lh;
      int    exp_cd;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic logic [1:0] px(input bit white);
      logic [1:0] v;
      v = white ? 2'b01 : 2'b00;
      if ($urandom_range(0, 1) == 1) v = ~v;
      return v;
   endfunction

   function automatic bit is_white(input int y, input int x);
      return (mem[y*IMG_W + x] == 2'b01) || (mem[y*IMG_W + x] == 2'b10);
   endfunction

   task automatic fill_pattern(input int kind, input int ww, input int wb,
                               input int row_lo, input int row_hi);
      bit w;
      for (int y = 0; y < IMG_H; y++) begin
         for (int x = 0; x < IMG_W; x++) begin
            if (kind == 0)
               w = (y >= row_lo) && (y <= row_hi) && (x >= BORDER) &&
                   (((x - BORDER) % (ww + wb)) < ww);
            else
               w = (x >= 20 && x < 60) || (x >= 100 && x < 140) || (x >= 180 && x < 220) ||
                   (x >= 420 && x < 460) || (x >= 500 && x < 540);
            mem[y*IMG_W + x] = px(w);
         end
      end
   endtask

   task automatic fill_random();
      int x;
      int len;
      bit w;
      for (int y = 0; y < IMG_H; y++) begin
         x = 0;
         w = ($urandom_range(0, 1) == 1);
         while (x < IMG_W) begin
            case ($urandom_range(0, 3))
               0:       len = $urandom_range(1, 12);
               1:       len = $urandom_range(4, 60);
               2:       len = $urandom_range(98, 135);
               default: len = $urandom_range(20, 45);
            endcase
            for (int i = 0; i < len && x < IMG_W; i++) begin
               mem[y*IMG_W + x] = px(w);
               x++;
            end
            w = !w;
         end
      end
   endtask

   // Reference: list the maximal white runs of each scan row, keep those
   // with a legal length, and derive the row count from that list.
   function automatic void model_frame(output int sc, output int lh, output int cd);
      int fmax;
      int hits;
      fmax = 0;
      hits = 0;
      for (int k = 0; k < NUM_LINES; k++) begin
         int y;
         int x;
         int s;
         int cnt;
         int bp [IMG_W+1];
         int st [$];
         int en [$];
`ifdef ZEBRA_GAP_CHECK_EN
         int seq;
         int gap;
         int prev_end;
`endif
         st.delete();
         en.delete();
         y = BORDER + k*PITCH;
         bp[BORDER] = 0;
         for (int i = BORDER; i < X_END; i++) bp[i+1] = bp[i] + (is_white(y, i) ? 0 : 1);
         x = BORDER;
         while (x < X_END) begin
            if (is_white(y, x)) begin
               s = x;
               while (x < X_END && is_white(y, x)) x++;
               if ((x - s) >= MIN_RUN && (x - s) <= MAX_RUN) begin
                  st.push_back(s);
                  en.push_back(x - 1);
               end
            end else begin
               x++;
            end
         end
`ifdef ZEBRA_GAP_CHECK_EN
         cnt = 0;
         seq = 0;
         prev_end = BORDER - 1;
         for (int i = 0; i < st.size(); i++) begin
            gap = bp[st[i]] - bp[prev_end + 1];
            seq = (gap > MAX_GAP) ? 1 : seq + 1;
            if (seq > cnt) cnt = seq;
            prev_end = en[i];
         end
`else
         cnt = st.size();
`endif
         if (cnt > 255) cnt = 255;
         if (cnt > fmax) fmax = cnt;
         if (cnt >= MIN_STRIPES) hits++;
      end
      sc = fmax;
      lh = hits;
      cd = (hits >= MIN_LINES) ? 1 : 0;
   endfunction

   // Requests a frame, waits (bounded) for the result and checks it.
   task automatic do_frame(input string name, input int es, input int el, input int ec);
      int lat;
      int sc;
      int lh;
      int cd;
      int busy_bad;
      int tail_bad;
      int rd_start;
      lat = -1; sc = 0; lh = 0; cd = 0; busy_bad = 0; tail_bad = 0;
      @(negedge clk);
      rst_n = 1'b1;
      valid_to_read = 1'b1;
      rd_start = rd_cnt;
      @(posedge clk);
      #1;
      valid_to_read = 1'b0;
      if (busy !== 1'b1) busy_bad = 1;
      for (int n = 1; n <= LAT + 50; n++) begin
         @(posedge clk);
         #1;
         if (busy !== 1'b1) busy_bad = 1;
         if (detection_valid === 1'b1) begin
            lat = n;
            sc = stripe_count;
            lh = lines_hit;
            cd = crossing_detected;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (detection_valid !== 1'b0 || busy !== 1'b0) tail_bad = 1;
      if (stripe_count != sc || lines_hit != lh || crossing_detected != cd) tail_bad = 1;
      check({name, ".latency"}, lat, LAT);
      check({name, ".stripe_count"}, sc, es);
      check({name, ".lines_hit"}, lh, el);
      check({name, ".crossing"}, cd, ec);
      check({name, ".busy_window"}, busy_bad, 0);
      check({name, ".pulse_and_hold"}, tail_bad, 0);
      check({name, ".reads"}, rd_cnt - rd_start, READS);
      $display("frame %s: latency=%0d stripe_count=%0d lines_hit=%0d crossing=%0d reads=%0d",
               name, lat, sc, lh, cd, rd_cnt - rd_start);
   endtask

   initial begin
      vec_t vecs [6];
      int es;
      int el;
      int ec;
      int seen;

      n_checks = 0;
      n_err = 0;
      rst_n = 1'b0;
      valid_to_read = 1'b0;

      vecs[0] = '{"all_black",   0,  0,   1,  0, IMG_H-1, 0,       0, 0};
      vecs[1] = '{"stripes40",   0, 40,  40,  0, IMG_H-1, 8,       8, 1};
      vecs[2] = '{"stripes4",    0,  4,   4,  0, IMG_H-1, 0,       0, 0};
      vecs[3] = '{"stripes200",  0, 200, 200, 0, IMG_H-1, 0,       0, 0};
      vecs[4] = '{"rows20_60",   0, 40,  40, 20, 60,      8,       1, 0};
      vecs[5] = '{"gap_pattern", 1,  0,   0,  0, 0,       GAP_EXP, 8, 1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset.busy", busy, 0);
      check("reset.detection_valid", detection_valid, 0);
      check("reset.rd_en", bram_rd_en, 0);
      check("reset.addr", bram_addr, 0);
      check("reset.stripe_count", stripe_count, 0);
      check("reset.lines_hit", lines_hit, 0);
      check("reset.crossing", crossing_detected, 0);

      // Directed table; the first frame is requested on the very edge
      // after reset is released.
      for (int i = 0; i < 6; i++) begin
         fill_pattern(vecs[i].kind, vecs[i].ww, vecs[i].wb, vecs[i].row_lo, vecs[i].row_hi);
         do_frame(vecs[i].name, vecs[i].exp_sc, vecs[i].exp_lh, vecs[i].exp_cd);
      end

      // Random frames against the reference model
      for (int r = 0; r < 4; r++) begin
         fill_random();
         model_frame(es, el, ec);
         do_frame($sformatf("random%0d", r), es, el, ec);
      end

      // Mid-frame reset: abort, no result pulse, outputs cleared
      fill_pattern(0, 40, 40, 0, IMG_H-1);
      @(negedge clk);
      valid_to_read = 1'b1;
      @(posedge clk);
      #1;
      valid_to_read = 1'b0;
      repeat (999) @(posedge clk);
      #2;
      check("abort.busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort.busy", busy, 0);
      check("abort.rd_en", bram_rd_en, 0);
      check("abort.stripe_count", stripe_count, 0);
      check("abort.lines_hit", lines_hit, 0);
      check("abort.crossing", crossing_detected, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int n = 0; n < LAT; n++) begin
         @(posedge clk);
         #1;
         if (detection_valid !== 1'b0 || busy !== 1'b0) seen = 1;
      end
      check("abort.no_activity", seen, 0);
      $display("abort: reset at cycle 1000, activity_after_reset=%0d", seen);
      do_frame("rerequest", 8, 8, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
